// File: rtl/flood_pkg.sv
// flood_pkg
// Shared definitions for the Flood-It turn sequencer:
//   - board and colour limits used to validate new-game requests
//   - FSM state encoding of the turn controller
//   - GAME_STATE codes reported to the display layer
//   - helpers that map an FSM state to BUSY and GAME_STATE
package flood_pkg;

  localparam int MAX_SIZE   = 26;
  localparam int MIN_SIZE   = 2;
  localparam int MAX_COLORS = 8;
  localparam int MIN_COLORS = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START_REQ,
    ST_START_REL,
    ST_PLAY,
    ST_ISSUE,
    ST_FILL_WAIT,
    ST_SCAN,
    ST_WON,
    ST_LOST
  } fsm_state_e;

  typedef enum logic [1:0] {
    GS_IDLE    = 2'd0,
    GS_PLAYING = 2'd1,
    GS_WON     = 2'd2,
    GS_LOST    = 2'd3
  } game_state_e;

  // Stable states are the ones where the player can act; everything else is busy.
  function automatic logic state_is_busy(input fsm_state_e s);
    return !(s inside {ST_IDLE, ST_PLAY, ST_WON, ST_LOST});
  endfunction

  function automatic game_state_e state_to_game(input fsm_state_e s);
    case (s)
      ST_IDLE: return GS_IDLE;
      ST_WON:  return GS_WON;
      ST_LOST: return GS_LOST;
      default: return GS_PLAYING;
    endcase
  endfunction

endpackage

// File: rtl/board_uniform_scanner.sv
// board_uniform_scanner
// Walks the board one cell per cycle (column fastest) through the single-cell
// read port and checks that every cell equals the colour just played.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   scan_en         high while the controller is in its scan state
//   size            latched board edge (2..26)
//   target_color    colour every cell must match
//   cell_color      combinational read data for (scan_row, scan_col)
//   scan_row/col    registered read address, parked at (0,0) when idle
//   scan_done       this cycle ends the scan (mismatch or last cell matched)
//   scan_match      scan ended with the whole board matching
module board_uniform_scanner
  import flood_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic [4:0] size,
  input  logic [2:0] target_color,
  input  logic [2:0] cell_color,
  output logic [4:0] scan_row,
  output logic [4:0] scan_col,
  output logic       scan_done,
  output logic       scan_match
);

  logic [4:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  logic       last_col;
  logic       last_row;
  logic       cell_match;

  // The verdict is combinational on the current cell so the controller can
  // leave the scan state on the same edge that retires the last cell.
  always_comb begin
    last_col   = (col_q == size - 5'd1);
    last_row   = (row_q == size - 5'd1);
    cell_match = (cell_color == target_color);
    scan_done  = scan_en && (!cell_match || (last_col && last_row));
    scan_match = scan_en && cell_match && last_col && last_row;

    row_d = row_q;
    col_d = col_q;
    // Address returns to the corner whenever the scan is idle or finishing,
    // which is what lets PLAY read the corner colour.
    if (!scan_en || scan_done) begin
      row_d = '0;
      col_d = '0;
    end else if (last_col) begin
      col_d = '0;
      row_d = row_q + 5'd1;
    end else begin
      col_d = col_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign scan_row = row_q;
  assign scan_col = col_q;

endmodule

// File: rtl/flood_turn_controller.sv
// flood_turn_controller
// Turn sequencer between the input layer and the Flood-It game logic.
// Accepts new-game requests and colour picks, runs the START_NEW_GAME and
// COLOR_SEL_SIG handshakes, counts moves and scans the board after each fill
// to decide between win, loss or another turn.
// Ports:
//   CLOCK, RESET                     clock, asynchronous active-high reset
//   NEW_GAME_REQ, SIZE, COLOR_NUM,
//   MAX_MOVES                        new-game request and its settings
//   PICK_VALID, PICK_COLOR           player colour pick
//   START_NEW_GAME / STARTED_GAME    new-game handshake with game logic
//   COLOR_SELECTED, COLOR_SEL_SIG /
//   CHANGING_COLOR                   fill handshake with game logic
//   SCAN_ROW, SCAN_COL / SCAN_COLOR  board read port
//   MOVE_COUNT, GAME_STATE, BUSY     status for the display layer
module flood_turn_controller
  import flood_pkg::*;
#(
  parameter int MAX_SIZE = flood_pkg::MAX_SIZE,
  parameter int MOVE_W   = 6
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              NEW_GAME_REQ,
  input  logic [4:0]        SIZE,
  input  logic [3:0]        COLOR_NUM,
  input  logic [MOVE_W-1:0] MAX_MOVES,
  input  logic              PICK_VALID,
  input  logic [2:0]        PICK_COLOR,
  output logic              START_NEW_GAME,
  input  logic              STARTED_GAME,
  output logic [2:0]        COLOR_SELECTED,
  output logic              COLOR_SEL_SIG,
  input  logic              CHANGING_COLOR,
  output logic [4:0]        SCAN_ROW,
  output logic [4:0]        SCAN_COL,
  input  logic [2:0]        SCAN_COLOR,
  output logic [MOVE_W-1:0] MOVE_COUNT,
  output logic [1:0]        GAME_STATE,
  output logic              BUSY
);

  fsm_state_e        state_q, state_d;
  logic              start_new_game_q, start_new_game_d;
  logic              color_sel_sig_q, color_sel_sig_d;
  logic [2:0]        color_selected_q, color_selected_d;
  logic [MOVE_W-1:0] move_count_q, move_count_d;
  game_state_e       game_state_q, game_state_d;
  logic              busy_q, busy_d;

  // Settings of the game in progress.
  logic [4:0]        size_q, size_d;
  logic [3:0]        color_num_q, color_num_d;
  logic [MOVE_W-1:0] max_moves_q, max_moves_d;

  // A request that arrived while busy, with the settings it carried.
  logic              pend_q, pend_d;
  logic [4:0]        pend_size_q, pend_size_d;
  logic [3:0]        pend_color_num_q, pend_color_num_d;
  logic [MOVE_W-1:0] pend_max_moves_q, pend_max_moves_d;

  logic              req_legal;
  logic              pick_ok;
  logic              scan_en;
  logic              scan_done;
  logic              scan_match;

  assign req_legal = NEW_GAME_REQ
                  && (SIZE >= 5'(MIN_SIZE)) && (SIZE <= 5'(MAX_SIZE))
                  && (COLOR_NUM >= 4'(MIN_COLORS)) && (COLOR_NUM <= 4'(MAX_COLORS));

  // In PLAY the scanner is parked on (0,0), so SCAN_COLOR is the corner colour;
  // replaying the corner colour would be a no-op move.
  assign pick_ok = PICK_VALID
                && ({1'b0, PICK_COLOR} < color_num_q)
                && (PICK_COLOR != SCAN_COLOR);

  assign scan_en = (state_q == ST_SCAN);

  board_uniform_scanner u_scanner (
    .clk          (CLOCK),
    .rst          (RESET),
    .scan_en      (scan_en),
    .size         (size_q),
    .target_color (color_selected_q),
    .cell_color   (SCAN_COLOR),
    .scan_row     (SCAN_ROW),
    .scan_col     (SCAN_COL),
    .scan_done    (scan_done),
    .scan_match   (scan_match)
  );

  always_comb begin
    state_d          = state_q;
    start_new_game_d = start_new_game_q;
    color_sel_sig_d  = color_sel_sig_q;
    color_selected_d = color_selected_q;
    move_count_d     = move_count_q;
    size_d           = size_q;
    color_num_d      = color_num_q;
    max_moves_d      = max_moves_q;
    pend_d           = pend_q;
    pend_size_d      = pend_size_q;
    pend_color_num_d = pend_color_num_q;
    pend_max_moves_d = pend_max_moves_q;

    // A request mid-handshake or mid-fill is remembered, not acted on; the
    // newest legal request's settings win.
    if (req_legal && state_is_busy(state_q)) begin
      pend_d           = 1'b1;
      pend_size_d      = SIZE;
      pend_color_num_d = COLOR_NUM;
      pend_max_moves_d = MAX_MOVES;
    end

    case (state_q)
      ST_IDLE, ST_PLAY, ST_WON, ST_LOST: begin
        // A new game outranks a same-cycle pick, which is simply dropped.
        if (req_legal) begin
          state_d          = ST_START_REQ;
          start_new_game_d = 1'b1;
          size_d           = SIZE;
          color_num_d      = COLOR_NUM;
          max_moves_d      = MAX_MOVES;
          pend_d           = 1'b0;
        end else if (pend_q) begin
          state_d          = ST_START_REQ;
          start_new_game_d = 1'b1;
          size_d           = pend_size_q;
          color_num_d      = pend_color_num_q;
          max_moves_d      = pend_max_moves_q;
          pend_d           = 1'b0;
        end else if ((state_q == ST_PLAY) && pick_ok) begin
          state_d          = ST_ISSUE;
          color_selected_d = PICK_COLOR;
          color_sel_sig_d  = 1'b1;
        end
      end
      ST_START_REQ: begin
        if (STARTED_GAME) begin
          start_new_game_d = 1'b0;
          state_d          = ST_START_REL;
        end
      end
      ST_START_REL: begin
        if (!STARTED_GAME) begin
          move_count_d = '0;
          state_d      = ST_PLAY;
        end
      end
      ST_ISSUE: begin
        // Dropping the strobe as soon as the fill starts guarantees it is
        // already low by the time CHANGING_COLOR falls.
        if (CHANGING_COLOR) begin
          color_sel_sig_d = 1'b0;
          if (move_count_q != {MOVE_W{1'b1}}) begin
            move_count_d = move_count_q + MOVE_W'(1);
          end
          state_d = ST_FILL_WAIT;
        end
      end
      ST_FILL_WAIT: begin
        if (!CHANGING_COLOR) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (scan_done) begin
          if (scan_match) begin
            state_d = ST_WON;
          end else if ((max_moves_q != '0) && (move_count_q == max_moves_q)) begin
            state_d = ST_LOST;
          end else begin
            state_d = ST_PLAY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status is registered from the next state so it lines up with the FSM.
    game_state_d = state_to_game(state_d);
    busy_d       = state_is_busy(state_d);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q          <= ST_IDLE;
      start_new_game_q <= 1'b0;
      color_sel_sig_q  <= 1'b0;
      color_selected_q <= '0;
      move_count_q     <= '0;
      game_state_q     <= GS_IDLE;
      busy_q           <= 1'b0;
      size_q           <= 5'(MIN_SIZE);
      color_num_q      <= 4'(MIN_COLORS);
      max_moves_q      <= '0;
      pend_q           <= 1'b0;
      pend_size_q      <= 5'(MIN_SIZE);
      pend_color_num_q <= 4'(MIN_COLORS);
      pend_max_moves_q <= '0;
    end else begin
      state_q          <= state_d;
      start_new_game_q <= start_new_game_d;
      color_sel_sig_q  <= color_sel_sig_d;
      color_selected_q <= color_selected_d;
      move_count_q     <= move_count_d;
      game_state_q     <= game_state_d;
      busy_q           <= busy_d;
      size_q           <= size_d;
      color_num_q      <= color_num_d;
      max_moves_q      <= max_moves_d;
      pend_q           <= pend_d;
      pend_size_q      <= pend_size_d;
      pend_color_num_q <= pend_color_num_d;
      pend_max_moves_q <= pend_max_moves_d;
    end
  end

  assign START_NEW_GAME = start_new_game_q;
  assign COLOR_SEL_SIG  = color_sel_sig_q;
  assign COLOR_SELECTED = color_selected_q;
  assign MOVE_COUNT     = move_count_q;
  assign GAME_STATE     = game_state_q;
  assign BUSY           = busy_q;

endmodule

// File: tb/tb_flood_turn_controller.sv
// tb_flood_turn_controller
// Bench for flood_turn_controller with a behavioural game-logic model
// (start handshake, timed fill, board memory behind the scan read port).
module tb_flood_turn_controller;

  localparam int START_LAT = 3;

  typedef struct {
    logic [2:0] pick;
    bit         win;
    bit         accept;
    int         mc;
    int         gs;
  } vec_t;

  typedef struct {
    logic [2:0] color;
    int         mc;
    int         gs;
    int         pulses;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       new_game_req;
  logic [4:0] size_in;
  logic [3:0] color_num_in;
  logic [5:0] max_moves_in;
  logic       pick_valid;
  logic [2:0] pick_color;
  logic       start_new_game;
  logic       started_game;
  logic [2:0] color_selected;
  logic       color_sel_sig;
  logic       changing_color;
  logic [4:0] scan_row;
  logic [4:0] scan_col;
  logic [2:0] scan_color;
  logic [5:0] move_count;
  logic [1:0] game_state;
  logic       busy;

  logic [2:0] board [0:31][0:31];
  bit         win_fill;
  int         board_reset_req;
  int         fill_events;

  int         scan_cycles;
  int         max_row;
  int         max_col;
  int         sel_pulses;
  int         sel_viol;

  int         vectors;
  int         miscompares;
  exp_t       sbq[$];
  logic [2:0] exp_color;

  flood_turn_controller dut (
    .CLOCK          (clock),
    .RESET          (reset),
    .NEW_GAME_REQ   (new_game_req),
    .SIZE           (size_in),
    .COLOR_NUM      (color_num_in),
    .MAX_MOVES      (max_moves_in),
    .PICK_VALID     (pick_valid),
    .PICK_COLOR     (pick_color),
    .START_NEW_GAME (start_new_game),
    .STARTED_GAME   (started_game),
    .COLOR_SELECTED (color_selected),
    .COLOR_SEL_SIG  (color_sel_sig),
    .CHANGING_COLOR (changing_color),
    .SCAN_ROW       (scan_row),
    .SCAN_COL       (scan_col),
    .SCAN_COLOR     (scan_color),
    .MOVE_COUNT     (move_count),
    .GAME_STATE     (game_state),
    .BUSY           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign scan_color = board[scan_row][scan_col];

  // Game-logic model: acknowledges START_NEW_GAME after START_LAT cycles,
  // runs a fill two cycles after COLOR_SEL_SIG and owns the board memory.
  initial begin : game_logic_model
    int start_cnt;
    int fill_phase;
    int seen_reset_req;
    start_cnt      = 0;
    fill_phase     = 0;
    seen_reset_req = 0;
    started_game   = 1'b0;
    changing_color = 1'b0;
    fill_events    = 0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        board[r][c] = 3'd0;
    forever begin
      @(posedge clock);
      #1;
      if (board_reset_req != seen_reset_req) begin
        seen_reset_req = board_reset_req;
        for (int r = 0; r < 32; r++)
          for (int c = 0; c < 32; c++)
            board[r][c] = 3'((r + c + 1) % 4);
      end
      if (reset) begin
        started_game   = 1'b0;
        changing_color = 1'b0;
        fill_phase     = 0;
        start_cnt      = 0;
      end else begin
        if (start_new_game && !started_game) begin
          start_cnt++;
          if (start_cnt == START_LAT) begin
            started_game = 1'b1;
            start_cnt    = 0;
          end
        end else if (started_game && !start_new_game) begin
          started_game = 1'b0;
        end
        if (fill_phase == 0) begin
          if (color_sel_sig) fill_phase = 1;
        end else begin
          fill_phase++;
          if (fill_phase == 3) changing_color = 1'b1;
          if (fill_phase == 6) begin
            if (win_fill) begin
              for (int r = 0; r < 32; r++)
                for (int c = 0; c < 32; c++)
                  board[r][c] = color_selected;
            end else begin
              board[0][0] = color_selected;
              board[0][1] = color_selected ^ 3'd1;
            end
            changing_color = 1'b0;
            fill_phase     = 0;
            fill_events++;
          end
        end
      end
    end
  end

  // Observer: counts COLOR_SEL_SIG pulses, busy cycles after each fill
  // (FILL_WAIT plus scan), the furthest scan address, and strobe-after-fill.
  initial begin : observer
    int  last_fill;
    bit  counting;
    logic prev_chg;
    logic prev_sel;
    last_fill   = 0;
    counting    = 0;
    prev_chg    = 1'b0;
    prev_sel    = 1'b0;
    scan_cycles = 0;
    max_row     = 0;
    max_col     = 0;
    sel_pulses  = 0;
    sel_viol    = 0;
    forever begin
      @(negedge clock);
      if (fill_events != last_fill) begin
        last_fill   = fill_events;
        scan_cycles = 0;
        max_row     = 0;
        max_col     = 0;
        counting    = 1;
      end
      if (counting && busy && !changing_color) begin
        scan_cycles++;
        if (int'(scan_row) > max_row) max_row = int'(scan_row);
        if (int'(scan_col) > max_col) max_col = int'(scan_col);
      end
      if (!busy) counting = 0;
      if (prev_chg && !changing_color && color_sel_sig) sel_viol++;
      if (color_sel_sig && !prev_sel) sel_pulses++;
      prev_chg = changing_color;
      prev_sel = color_sel_sig;
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic initBoard();
    board_reset_req++;
    @(posedge clock);
    #2;
  endtask

  task automatic pulseReq(input logic [4:0] sz, input logic [3:0] cn, input logic [5:0] mm);
    @(posedge clock);
    #1;
    new_game_req = 1'b1;
    size_in      = sz;
    color_num_in = cn;
    max_moves_in = mm;
    @(posedge clock);
    #1;
    new_game_req = 1'b0;
  endtask

  task automatic waitNotBusy(input string what, input int budget, output int sng_hi);
    int n;
    n      = 0;
    sng_hi = 0;
    do begin
      @(negedge clock);
      if (start_new_game) sng_hi++;
      n++;
    end while (busy && n < budget);
    checkOutput({what, "_idle"}, busy, 0);
  endtask

  task automatic waitChanging(input string what);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!changing_color && n < 30);
    checkOutput({what, "_fill_started"}, changing_color, 1);
  endtask

  task automatic startGame(input logic [4:0] sz, input logic [3:0] cn, input logic [5:0] mm);
    int hi;
    pulseReq(sz, cn, mm);
    @(negedge clock);
    checkOutput("sng_latency", start_new_game, 1);
    waitNotBusy("start", 60, hi);
    checkOutput("sng_width", hi + 1, START_LAT);
    checkOutput("gs_after_start", game_state, 1);
    checkOutput("mc_after_start", move_count, 0);
  endtask

  // Drive one pick and push what the turn must end with onto the scoreboard.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   dummy;
    if (v.accept) exp_color = v.pick;
    e.color  = exp_color;
    e.mc     = v.mc;
    e.gs     = v.gs;
    e.pulses = sel_pulses + (v.accept ? 1 : 0);
    sbq.push_back(e);
    win_fill = v.win;
    @(posedge clock);
    #1;
    pick_valid = 1'b1;
    pick_color = v.pick;
    @(posedge clock);
    #1;
    pick_valid = 1'b0;
    repeat (2) @(negedge clock);
    waitNotBusy("turn", 400, dummy);
  endtask

  task automatic checkTurn(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      checkOutput({name, "_sb_empty"}, 0, 1);
    end else begin
      e = sbq.pop_front();
      checkOutput({name, "_move_count"}, move_count, e.mc);
      checkOutput({name, "_game_state"}, game_state, e.gs);
      checkOutput({name, "_color_selected"}, color_selected, e.color);
      checkOutput({name, "_sel_pulses"}, sel_pulses, e.pulses);
    end
  endtask

  initial begin : main
    vec_t game1 [7];
    vec_t v;
    int   hi;
    int   n;
    logic [4:0] bad_size [5];
    logic [3:0] bad_cn   [5];

    vectors      = 0;
    miscompares  = 0;
    exp_color    = 3'd0;
    reset        = 1'b1;
    new_game_req = 1'b0;
    size_in      = 5'd0;
    color_num_in = 4'd0;
    max_moves_in = 6'd0;
    pick_valid   = 1'b0;
    pick_color   = 3'd0;
    win_fill     = 1'b0;
    board_reset_req = 0;

    // pick, win fill, accepted, move count, game state after the turn
    game1[0] = '{3'd2, 1'b0, 1'b1, 1, 1};
    game1[1] = '{3'd2, 1'b0, 1'b0, 1, 1};
    game1[2] = '{3'd5, 1'b0, 1'b0, 1, 1};
    game1[3] = '{3'd4, 1'b0, 1'b0, 1, 1};
    game1[4] = '{3'd3, 1'b0, 1'b1, 2, 1};
    game1[5] = '{3'd0, 1'b0, 1'b1, 3, 3};
    game1[6] = '{3'd1, 1'b0, 1'b0, 3, 3};

    bad_size[0] = 5'd30; bad_cn[0] = 4'd4;
    bad_size[1] = 5'd27; bad_cn[1] = 4'd4;
    bad_size[2] = 5'd1;  bad_cn[2] = 4'd4;
    bad_size[3] = 5'd6;  bad_cn[3] = 4'd9;
    bad_size[4] = 5'd6;  bad_cn[4] = 4'd1;

    repeat (2) @(negedge clock);
    checkOutput("rst_start_new_game", start_new_game, 0);
    checkOutput("rst_color_sel_sig", color_sel_sig, 0);
    checkOutput("rst_color_selected", color_selected, 0);
    checkOutput("rst_scan_row", scan_row, 0);
    checkOutput("rst_scan_col", scan_col, 0);
    checkOutput("rst_move_count", move_count, 0);
    checkOutput("rst_game_state", game_state, 0);
    checkOutput("rst_busy", busy, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] game 1: 6x6, 4 colours, move limit 3");
    startGame(5'd6, 4'd4, 6'd3);
    initBoard();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(game1[i]);
      checkTurn($sformatf("g1_v%0d", i));
    end

    $display("[TB] game 2: uniform board after one pick");
    startGame(5'd6, 4'd4, 6'd0);
    initBoard();
    v = '{3'd2, 1'b1, 1'b1, 1, 2};
    applyStimulus(v);
    checkTurn("g2_win");
    checkOutput("g2_scan_cycles", scan_cycles, 6 * 6 + 1);
    checkOutput("g2_max_row", max_row, 5);
    checkOutput("g2_max_col", max_col, 5);
    v = '{3'd3, 1'b0, 1'b0, 1, 2};
    applyStimulus(v);
    checkTurn("g2_pick_after_win");

    $display("[TB] game 3: request during fill is deferred");
    startGame(5'd6, 4'd4, 6'd0);
    initBoard();
    win_fill = 1'b0;
    @(posedge clock);
    #1;
    pick_valid = 1'b1;
    pick_color = 3'd3;
    @(posedge clock);
    #1;
    pick_valid = 1'b0;
    waitChanging("g3");
    pulseReq(5'd3, 4'd3, 6'd0);
    @(negedge clock);
    checkOutput("g3_sng_deferred", start_new_game, 0);
    n = 0;
    while (!start_new_game && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("g3_restart_seen", start_new_game, 1);
    checkOutput("g3_mc_before_restart", move_count, 1);
    waitNotBusy("g3_restart", 60, hi);
    checkOutput("g3_gs_after_restart", game_state, 1);
    checkOutput("g3_mc_after_restart", move_count, 0);

    // Same-cycle pick and new game: the new game wins.
    initBoard();
    @(posedge clock);
    #1;
    new_game_req = 1'b1;
    size_in      = 5'd3;
    color_num_in = 4'd3;
    max_moves_in = 6'd0;
    pick_valid   = 1'b1;
    pick_color   = 3'd2;
    @(posedge clock);
    #1;
    new_game_req = 1'b0;
    pick_valid   = 1'b0;
    @(negedge clock);
    checkOutput("g3_both_sng", start_new_game, 1);
    checkOutput("g3_both_sel", color_sel_sig, 0);
    waitNotBusy("g3_both", 60, hi);
    checkOutput("g3_both_mc", move_count, 0);
    v = '{3'd2, 1'b1, 1'b1, 1, 2};
    applyStimulus(v);
    checkTurn("g3_win_3x3");
    checkOutput("g3_scan_cycles", scan_cycles, 3 * 3 + 1);
    checkOutput("g3_max_row", max_row, 2);

    $display("[TB] illegal new-game requests");
    for (int i = 0; i < 5; i++) begin
      pulseReq(bad_size[i], bad_cn[i], 6'd0);
      @(negedge clock);
      checkOutput($sformatf("bad_req%0d_sng", i), start_new_game, 0);
      checkOutput($sformatf("bad_req%0d_gs", i), game_state, 2);
    end

    $display("[TB] reset during fill, 26x26, 8 colours");
    startGame(5'd26, 4'd8, 6'd0);
    initBoard();
    win_fill = 1'b0;
    @(posedge clock);
    #1;
    pick_valid = 1'b1;
    pick_color = 3'd7;
    @(posedge clock);
    #1;
    pick_valid = 1'b0;
    waitChanging("rstfill");
    checkOutput("rstfill_sel_before", color_sel_sig, 1);
    reset = 1'b1;
    #1;
    checkOutput("rstfill_sel", color_sel_sig, 0);
    checkOutput("rstfill_busy", busy, 0);
    checkOutput("rstfill_gs", game_state, 0);
    checkOutput("rstfill_color", color_selected, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("after_reset_gs", game_state, 0);
    checkOutput("after_reset_sng", start_new_game, 0);

    checkOutput("sel_after_fill_violations", sel_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
